local_max_scan_ctrl: RTL and testbench

- Raster-scan sequencer for 8-bit local-maxima detection over an IMG_W x IMG_H frame.
- Accepts the frame as a pixel stream and keeps a sliding 3x3 window in shift-register line storage.
- Drives one compare_neighbor instance with the window center, its 8 neighbors and plateau-resolution flags.
- Emits one registered maximum flag per pixel, in raster order, with row/col tags and valid/ready backpressure.

---
 rtl/lm_pkg.sv | 30 +++
 rtl/compare_neighbor.sv | 28 ++
 rtl/lm_window_buf.sv | 85 ++++++++
 rtl/local_max_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_local_max_scan_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lm_pkg.sv
// Shared types and constants for the local-maximum raster scanner.
package lm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH,
    DONE
  } state_t;

  typedef logic [7:0] pix_t;

  // Neighbor slots. The first four precede the center in raster order,
  // so their plateau flags are already known when the center is evaluated.
  localparam int NB_NW    = 0;
  localparam int NB_N     = 1;
  localparam int NB_NE    = 2;
  localparam int NB_W     = 3;
  localparam int NB_E     = 4;
  localparam int NB_SW    = 5;
  localparam int NB_S     = 6;
  localparam int NB_SE    = 7;
  localparam int NB_COUNT = 8;
  localparam int NB_EARLY = 4;

  // Value presented for neighbors that fall outside the frame.
  localparam pix_t PAD_VAL = 8'd0;

endpackage

// File: rtl/compare_neighbor.sv
// Decides whether a center pixel is a local maximum against its 8 neighbors,
// resolving plateaus through each neighbor's res flag.
module compare_neighbor
  import lm_pkg::*;
(
  input  pix_t                  i_center,
  input  pix_t [NB_COUNT-1:0]   i_nbr,
  input  logic [NB_COUNT-1:0]   i_res,
  output logic                  o_max
);

  logic w_any_gt;
  logic w_tie_blocked;

  // Scan all neighbors: any larger one, or an equal one that is not itself resolved, vetoes the center.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    w_any_gt      = 1'b0;
    w_tie_blocked = 1'b0;
    for (int i = 0; i < NB_COUNT; i++) begin
      if (i_nbr[i] > i_center) w_any_gt = 1'b1;
      if ((i_nbr[i] == i_center) && !i_res[i]) w_tie_blocked = 1'b1;
    end
  end

  assign o_max = !w_any_gt && !w_tie_blocked;

endmodule

// File: rtl/lm_window_buf.sv
// Sliding 3x3 window: pixel line storage, stored result flags of the earlier
// neighbors, and the out-of-frame padding muxes.
module lm_window_buf
  import lm_pkg::*;
#(
  parameter int IMG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_pix_shift,
  input  pix_t                 i_pix,
  input  logic                 i_res_shift,
  input  logic                 i_res,
  input  logic                 i_top,
  input  logic                 i_bot,
  input  logic                 i_left,
  input  logic                 i_right,
  output pix_t                 o_center,
  output pix_t [NB_COUNT-1:0]  o_nbr,
  output logic [NB_EARLY-1:0]  o_res_early
);

  // Entry j holds the pixel accepted j+1 shifts ago; with the incoming pixel
  // this spans NW (2*IMG_W+2 back) through SE (the incoming pixel itself).
  localparam int PIX_D = 2*IMG_W + 2;
  localparam int RES_D = IMG_W + 1;

  pix_t               r_pix [PIX_D];
  logic [RES_D-1:0]   r_res;
  pix_t [NB_COUNT-1:0] w_raw;
  logic [NB_COUNT-1:0] w_out;

  // Shift pixels and result flags one raster position per accepted/evaluated slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the line store is small and cleared on reset so a fresh frame never sees stale data.
      for (int j = 0; j < PIX_D; j++) r_pix[j] <= PAD_VAL;
      r_res <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage read its neighbor's old value, forming a shift chain.
      if (i_pix_shift) begin
        r_pix[0] <= i_pix;
        for (int j = 1; j < PIX_D; j++) r_pix[j] <= r_pix[j-1];
      end
      if (i_res_shift) r_res <= {r_res[RES_D-2:0], i_res};
    end
  end

  // Tap the window out of the line store and replace out-of-frame neighbors with padding.
  always_comb begin
    w_raw        = '0;
    w_out        = '0;
    o_nbr        = '0;
    o_res_early  = '0;

    w_raw[NB_NW] = r_pix[2*IMG_W+1];
    w_raw[NB_N]  = r_pix[2*IMG_W];
    w_raw[NB_NE] = r_pix[2*IMG_W-1];
    w_raw[NB_W]  = r_pix[IMG_W+1];
    w_raw[NB_E]  = r_pix[IMG_W-1];
    w_raw[NB_SW] = r_pix[1];
    w_raw[NB_S]  = r_pix[0];
    w_raw[NB_SE] = i_pix;

    // Column gating keeps the window from wrapping across row boundaries.
    w_out[NB_NW] = i_top | i_left;
    w_out[NB_N]  = i_top;
    w_out[NB_NE] = i_top | i_right;
    w_out[NB_W]  = i_left;
    w_out[NB_E]  = i_right;
    w_out[NB_SW] = i_bot | i_left;
    w_out[NB_S]  = i_bot;
    w_out[NB_SE] = i_bot | i_right;

    for (int i = 0; i < NB_COUNT; i++) o_nbr[i] = w_out[i] ? PAD_VAL : w_raw[i];

    o_res_early[NB_NW] = w_out[NB_NW] | r_res[IMG_W];
    o_res_early[NB_N]  = w_out[NB_N]  | r_res[IMG_W-1];
    o_res_early[NB_NE] = w_out[NB_NE] | r_res[IMG_W-2];
    o_res_early[NB_W]  = w_out[NB_W]  | r_res[0];
  end

  assign o_center = r_pix[IMG_W];

endmodule

// File: rtl/local_max_scan_ctrl.sv
// Raster-scan sequencer: streams a frame in, evaluates each pixel as a local
// maximum once its full window is available, and streams tagged flags out.
module local_max_scan_ctrl
  import lm_pkg::*;
#(
  parameter  int IMG_W = 8,
  parameter  int IMG_H = 8,
  localparam int RW    = $clog2(IMG_H),
  localparam int CW    = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    pix_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic          max_flag,
  output logic [RW-1:0] max_row,
  output logic [CW-1:0] max_col,
  output logic          max_valid,
  input  logic          max_ready,
  output logic          busy,
  output logic          done
);

  localparam int N_PIX = IMG_W * IMG_H;
  localparam int LAG   = IMG_W + 1;
  localparam int IW    = $clog2(N_PIX);

  localparam logic [IW-1:0] IDX_FILL_END = IW'(LAG - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(N_PIX - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [IW-1:0]       r_in_idx;
  logic [RW-1:0]       r_out_row;
  logic [CW-1:0]       r_out_col;
  logic                r_last_issued;
  logic                r_max_valid;
  logic                r_max_flag;
  logic [RW-1:0]       r_max_row;
  logic [CW-1:0]       r_max_col;

  logic                w_slot_free;
  logic                w_pix_acc;
  logic                w_eval;
  logic                w_last_center;
  logic                w_is_max;
  pix_t                w_center;
  pix_t [NB_COUNT-1:0] w_nbr;
  logic [NB_EARLY-1:0] w_res_early;

  assign w_slot_free   = !r_max_valid || max_ready;
  assign w_pix_acc     = pix_valid && pix_ready;
  // RUN evaluates on every accepted pixel; FLUSH on every free output slot until the last center.
  assign w_eval        = ((r_state == RUN) && w_pix_acc) ||
                         ((r_state == FLUSH) && w_slot_free && !r_last_issued);
  assign w_last_center = (r_out_row == ROW_LAST) && (r_out_col == COL_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (start) w_next_state = FILL;
      FILL:  if (w_pix_acc && (r_in_idx == IDX_FILL_END)) w_next_state = RUN;
      RUN:   if (w_pix_acc && (r_in_idx == IDX_LAST)) w_next_state = FLUSH;
      FLUSH: if (r_last_issued && r_max_valid && max_ready) w_next_state = DONE;
      DONE:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Moore outputs and input-side handshake.
  always_comb begin
    busy      = (r_state == FILL) || (r_state == RUN) || (r_state == FLUSH);
    done      = (r_state == DONE);
    pix_ready = ((r_state == FILL) || (r_state == RUN)) && w_slot_free;
  end

  // Input index and output center coordinates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_idx      <= '0;
      r_out_row     <= '0;
      r_out_col     <= '0;
      r_last_issued <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_in_idx      <= '0;
      r_out_row     <= '0;
      r_out_col     <= '0;
      r_last_issued <= 1'b0;
    end else begin
      if (w_pix_acc) r_in_idx <= r_in_idx + 1'b1;
      if (w_eval) begin
        if (r_out_col == COL_LAST) begin
          r_out_col <= '0;
          r_out_row <= r_out_row + 1'b1;
        end else begin
          r_out_col <= r_out_col + 1'b1;
        end
        if (w_last_center) r_last_issued <= 1'b1;
      end
    end
  end

  // Result register: a new evaluation loads even while the previous result is being taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_max_valid <= 1'b0;
      r_max_flag  <= 1'b0;
      r_max_row   <= '0;
      r_max_col   <= '0;
    end else if (w_eval) begin
      r_max_valid <= 1'b1;
      r_max_flag  <= w_is_max;
      r_max_row   <= r_out_row;
      r_max_col   <= r_out_col;
    end else if (max_ready) begin
      r_max_valid <= 1'b0;
    end
  end

  assign max_valid = r_max_valid;
  assign max_flag  = r_max_flag;
  assign max_row   = r_max_row;
  assign max_col   = r_max_col;

  lm_window_buf #(
    .IMG_W (IMG_W)
  ) u_window (
    .clk         (clk),
    .rst         (rst),
    .i_pix_shift (w_pix_acc || w_eval),
    .i_pix       (w_pix_acc ? pix_in : PAD_VAL),
    .i_res_shift (w_eval),
    .i_res       (w_is_max),
    .i_top       (r_out_row == '0),
    .i_bot       (r_out_row == ROW_LAST),
    .i_left      (r_out_col == '0),
    .i_right     (r_out_col == COL_LAST),
    .o_center    (w_center),
    .o_nbr       (w_nbr),
    .o_res_early (w_res_early)
  );

  // Later-raster neighbors are always treated as resolved.
  compare_neighbor u_cmp (
    .i_center (w_center),
    .i_nbr    (w_nbr),
    .i_res    ({4'b1111, w_res_early}),
    .o_max    (w_is_max)
  );

endmodule

// File: tb/tb_local_max_scan_ctrl.sv
// Self-checking bench for local_max_scan_ctrl on a 4x4 frame.
module tb_local_max_scan_ctrl;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int N   = W * H;
  localparam int LAG = W + 1;
  localparam int RW  = $clog2(H);
  localparam int CW  = $clog2(W);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic          max_flag;
  logic [RW-1:0] max_row;
  logic [CW-1:0] max_col;
  logic          max_valid;
  logic          max_ready;
  logic          busy;
  logic          done;

  int   errors = 0;
  int   checks = 0;
  logic [7:0] frame    [N];
  bit         exp_flag [N];
  bit         obs_flag [N];

  always #5 clk = ~clk;

  local_max_scan_ctrl #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .max_flag  (max_flag),
    .max_row   (max_row),
    .max_col   (max_col),
    .max_valid (max_valid),
    .max_ready (max_ready),
    .busy      (busy),
    .done      (done)
  );

  // Reference: walk the frame in raster order applying the maximum / plateau rules directly.
  task automatic build_expected();
    for (int idx = 0; idx < N; idx++) begin
      int r  = idx / W;
      int c  = idx % W;
      bit ok = 1'b1;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          int rr = r + dr;
          int cc = c + dc;
          int nv;
          bit nres;
          if (dr == 0 && dc == 0) continue;
          if (rr < 0 || rr >= H || cc < 0 || cc >= W) begin
            nv   = 0;
            nres = 1'b1;
          end else begin
            nv   = int'(frame[rr*W+cc]);
            nres = (rr*W + cc < idx) ? exp_flag[rr*W+cc] : 1'b1;
          end
          if (nv > int'(frame[idx])) ok = 1'b0;
          if (nv == int'(frame[idx]) && !nres) ok = 1'b0;
        end
      end
      exp_flag[idx] = ok;
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) frame[i] = 8'(i);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < N; i++) frame[i] = v;
  endtask

  task automatic fill_random(input int maxv);
    for (int i = 0; i < N; i++) frame[i] = 8'($urandom_range(maxv));
  endtask

  function automatic int count_obs();
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(obs_flag[i]);
    return n;
  endfunction

  // Drive one full frame with the given traffic shape and check every cycle against the reference.
  task automatic run_frame(input string name, input int valid_pct, input int ready_pct,
                           input bit stall, input bit extra_start, input int idle_valid,
                           input bit full_rate);
    int            pix_i = 0;
    int            res_i = 0;
    int            first_cyc = -1;
    int            last_cyc = -1;
    int            stall_left = 0;
    bit            last_hs = 0, finished = 0, prev_hold = 0, prev_acc = 0;
    bit            seen_valid = 0, stall_done = 0, extra_done = 0;
    logic          prev_flag = 1'b0;
    logic [RW-1:0] prev_row = '0;
    logic [CW-1:0] prev_col = '0;
    logic          exp_pr;
    build_expected();
    for (int i = 0; i < N; i++) obs_flag[i] = 1'b0;

    for (int i = 0; i < idle_valid; i++) begin
      @(negedge clk);
      start = 1'b0; pix_valid = 1'b1; pix_in = frame[0]; max_ready = 1'b1;
      #1;
      checks++;
      if (pix_ready !== 1'b0 || busy !== 1'b0)
        begin errors++; $display("FAIL %s idle_accept: pix_ready=%b busy=%b required 0 0", name, pix_ready, busy); end
    end

    @(negedge clk);
    start = 1'b1; pix_valid = (idle_valid > 0); pix_in = frame[0]; max_ready = 1'b1;
    #1;
    checks++;
    if (pix_ready !== 1'b0 || max_valid !== 1'b0)
      begin errors++; $display("FAIL %s start_cycle: pix_ready=%b max_valid=%b required 0 0", name, pix_ready, max_valid); end

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (extra_start && !extra_done && pix_i == N/2) begin start = 1'b1; extra_done = 1; end
      pix_valid = (pix_i < N) && (int'($urandom_range(99)) < valid_pct);
      pix_in    = pix_valid ? frame[pix_i] : 8'($urandom);
      if (stall && !stall_done && res_i == 4) begin stall_left = 3; stall_done = 1; end
      if (stall_left > 0) begin max_ready = 1'b0; stall_left--; end
      else max_ready = (int'($urandom_range(99)) < ready_pct);
      #1;

      if (last_hs) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || max_valid !== 1'b0)
          begin errors++; $display("FAIL %s done_pulse: done=%b busy=%b max_valid=%b required 1 0 0", name, done, busy, max_valid); end
        finished = 1;
      end else begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1)
          begin errors++; $display("FAIL %s busy_phase cyc=%0d: done=%b busy=%b required 0 1", name, cyc, done, busy); end

        exp_pr = (pix_i < N) && (!max_valid || max_ready);
        checks++;
        if (pix_ready !== exp_pr)
          begin errors++; $display("FAIL %s pix_ready cyc=%0d: got %b required %b", name, cyc, pix_ready, exp_pr); end

        if (prev_hold) begin
          checks++;
          if (max_valid !== 1'b1 || max_flag !== prev_flag || max_row !== prev_row || max_col !== prev_col)
            begin errors++; $display("FAIL %s hold cyc=%0d: got v=%b f=%b r=%0d c=%0d required v=1 f=%b r=%0d c=%0d",
                                     name, cyc, max_valid, max_flag, max_row, max_col, prev_flag, prev_row, prev_col); end
        end

        if (max_valid === 1'b1 && !seen_valid) begin
          seen_valid = 1;
          checks++;
          if (pix_i != LAG + 1 || !prev_acc)
            begin errors++; $display("FAIL %s first_latency: accepted=%0d prev_acc=%b required %0d 1", name, pix_i, prev_acc, LAG+1); end
        end

        if (max_valid === 1'b1 && max_ready === 1'b1) begin
          checks++;
          if (res_i >= N) begin
            errors++; $display("FAIL %s extra_result: got result %0d required at most %0d", name, res_i + 1, N);
          end else begin
            if (max_row !== RW'(res_i / W) || max_col !== CW'(res_i % W) || max_flag !== exp_flag[res_i])
              begin errors++; $display("FAIL %s result%0d: got r=%0d c=%0d f=%b required r=%0d c=%0d f=%b",
                                       name, res_i, max_row, max_col, max_flag, res_i / W, res_i % W, exp_flag[res_i]); end
            obs_flag[res_i] = max_flag;
            if (res_i == 0) first_cyc = cyc;
            res_i++;
            if (res_i == N) begin last_hs = 1; last_cyc = cyc; end
          end
        end

        prev_hold = (max_valid === 1'b1) && (max_ready === 1'b0);
        prev_flag = max_flag; prev_row = max_row; prev_col = max_col;
        prev_acc  = pix_valid && (pix_ready === 1'b1);
        if (prev_acc) pix_i++;
      end
    end

    checks++;
    if (!finished)
      begin errors++; $display("FAIL %s timeout: results=%0d required %0d", name, res_i, N); end
    if (full_rate) begin
      checks++;
      if (last_cyc - first_cyc != N - 1)
        begin errors++; $display("FAIL %s throughput: span=%0d required %0d", name, last_cyc - first_cyc, N - 1); end
    end

    @(negedge clk);
    start = 1'b0; pix_valid = 1'b0; max_ready = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || max_valid !== 1'b0)
      begin errors++; $display("FAIL %s after_done: done=%b busy=%b max_valid=%b required 0 0 0", name, done, busy, max_valid); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0; max_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({pix_ready, max_flag, max_row, max_col, max_valid, busy, done} !== '0)
      begin errors++; $display("FAIL reset_outputs: pr=%b f=%b r=%0d c=%0d v=%b busy=%b done=%b required all 0",
                               pix_ready, max_flag, max_row, max_col, max_valid, busy, done); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    fill_ramp();
    run_frame("ramp", 100, 100, 0, 0, 0, 1);
    checks++;
    if (count_obs() != 1 || obs_flag[N-1] !== 1'b1)
      begin errors++; $display("FAIL ramp_flags: count=%0d last=%b required 1 1", count_obs(), obs_flag[N-1]); end
  endtask

  task automatic test_plateau();
    fill_const(8'd5);
    frame[0] = 8'd9;
    run_frame("plateau", 100, 100, 0, 0, 0, 1);
    checks++;
    if (count_obs() != 1 || obs_flag[0] !== 1'b1 || obs_flag[2] !== 1'b0)
      begin errors++; $display("FAIL plateau_flags: count=%0d f00=%b f02=%b required 1 1 0",
                               count_obs(), obs_flag[0], obs_flag[2]); end
  endtask

  task automatic test_zeros();
    fill_const(8'd0);
    run_frame("zeros", 100, 100, 0, 0, 0, 1);
    checks++;
    if (count_obs() != N)
      begin errors++; $display("FAIL zeros_flags: count=%0d required %0d", count_obs(), N); end
  endtask

  task automatic test_backpressure();
    fill_random(255);
    run_frame("backpressure", 100, 100, 1, 0, 0, 0);
  endtask

  task automatic test_rst_midframe();
    int acc = 0;
    fill_ramp();
    @(negedge clk);
    start = 1'b1; pix_valid = 1'b0; max_ready = 1'b1;
    for (int cyc = 0; cyc < 50 && acc < 7; cyc++) begin
      @(negedge clk);
      start = 1'b0; pix_valid = 1'b1; pix_in = frame[acc];
      #1;
      if (pix_ready === 1'b1) acc++;
    end
    @(negedge clk);
    pix_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({pix_ready, max_flag, max_row, max_col, max_valid, busy, done} !== '0 || acc != 7)
      begin errors++; $display("FAIL rst_midframe: pr=%b f=%b r=%0d c=%0d v=%b busy=%b done=%b acc=%0d required all 0 acc=7",
                               pix_ready, max_flag, max_row, max_col, max_valid, busy, done, acc); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0)
        begin errors++; $display("FAIL rst_no_done: done=%b busy=%b required 0 0", done, busy); end
    end
    run_frame("ramp_after_rst", 100, 100, 0, 0, 0, 1);
  endtask

  task automatic test_ignored_inputs();
    fill_ramp();
    run_frame("ignored_start", 100, 100, 0, 1, 3, 1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      fill_random((f % 2 == 0) ? 2 : 255);
      run_frame("random", 40 + 10 * f, 90 - 10 * f, 0, 0, f % 3, 0);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_plateau();
    test_zeros();
    test_backpressure();
    test_rst_midframe();
    test_ignored_inputs();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
